uart_tx_mmio: RTL and testbench



---
 rtl/uart_tx_mmio.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter on the CPU data bus.
// CPU stores to TXDATA push bytes into a TX FIFO, and a baud-timed FSM
// serialises them LSB first on tx. Load instructions can read STATUS.
//
// Ports:
//   clk   - system clock, rising edge
//   rstn  - asynchronous active-low reset
//   we    - bus write enable
//   addr  - bus byte address; a 16-byte window at BASE_ADDR
//   wd    - bus write data
//   rd    - bus read data, combinational, no read side effects
//   tx    - registered serial output, idles high
//
// Register map, selected by addr[3:2]; addr[1:0] is ignored:
//   0x0 TXDATA  write pushes wd[7:0]; reads return 0
//   0x4 STATUS  [0] empty [1] full [2] busy [3] overflow [15:8] count
//               writing wd[3]=1 clears overflow
//   0x8, 0xC    reads return 0, writes are ignored
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          empty, full, busy, overflow;
  logic          sel, push, push_ok, pop, ovf_set, ovf_clr;
  logic          unused_bits;

  // Bus decode
  assign sel     = (addr[31:4] == BASE_ADDR[31:4]);
  assign push    = we && sel && (addr[3:2] == 2'd0);
  assign ovf_clr = we && sel && (addr[3:2] == 2'd1) && wd[3];

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign busy    = (state != IDLE);

  // Full is judged on the pre-edge count, so a push into a full FIFO is
  // dropped even when the FSM pops in the same cycle.
  assign push_ok = push && !full;
  assign ovf_set = push && full;
  assign pop     = (state == IDLE) && !empty;

  assign unused_bits = ^{addr[1:0], wd[31:8]};

  // FIFO pointers, count and sticky overflow
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      // Set has priority over a same-cycle clear
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Storage needs no reset: only entries covered by count are ever read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wd[7:0];
  end

  // Serialiser state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  // Next state. tx is derived from the next state and shift value, so the
  // registered output changes on the same edge the state does.
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_n = START;
          baud_n  = '0;
          shift_n = mem[rptr];
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          state_n   = DATA;
          baud_n    = '0;
          bit_idx_n = '0;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 1'b1;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          state_n = IDLE;
          baud_n  = '0;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  // Read mux
  always_comb begin
    rd = '0;
    if (sel && (addr[3:2] == 2'd1)) begin
      rd = {16'h0000, 8'(count), 4'h0, overflow, busy, full, empty};
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLK_DIV=4 and FIFO_DEPTH=8.
// A bench-side 8N1 receiver samples tx mid-bit and logs each decoded byte
// and the cycle its start bit was first seen.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DIV   = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned GAP   = 10 * DIV + 1;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        we   = 1'b0;
  logic [31:0] addr = BASE + 32'h4;
  logic [31:0] wd   = '0;
  logic [31:0] rd;
  logic        tx;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0]  rx_q[$];
  int unsigned rx_start[$];
  int unsigned cyc = 0;

  uart_tx_mmio #(
    .BASE_ADDR (BASE),
    .CLK_DIV   (DIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .we  (we),
    .addr(addr),
    .wd  (wd),
    .rd  (rd),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    we   = 1'b1;
    addr = a;
    wd   = d;
    tick();
    we   = 1'b0;
    addr = BASE + 32'h4;
    #1;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rd, exp);
  endtask

  // Receiver: one sample per clock at the falling edge
  initial begin
    int unsigned pos;
    logic [7:0]  sh;
    bit          active;
    pos = 0;
    sh = '0;
    active = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          pos = 0;
          rx_start.push_back(cyc);
        end
      end else begin
        pos++;
        if (pos == DIV / 2) begin
          check("rx_start_bit", 32'(tx), 32'h0);
        end else if (pos >= DIV && pos < 9 * DIV && (pos % DIV) == DIV / 2) begin
          sh = {tx, sh[7:1]};
        end else if (pos == 9 * DIV + DIV / 2) begin
          check("rx_stop_bit", 32'(tx), 32'h1);
          rx_q.push_back(sh);
          active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  b;
    int unsigned low_cnt;
    int unsigned waited;

    // 1. Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'h1);
    read_check("rst_status", BASE + 32'h4, 32'h0000_0001);
    rstn = 1'b1;
    tick();
    read_check("post_rst_status", BASE + 32'h4, 32'h0000_0001);
    read_check("txdata_read", BASE, 32'h0);
    check("post_rst_tx", 32'(tx), 32'h1);

    // 2. Single frame of 8'h55, checked cycle by cycle
    rx_q.delete();
    rx_start.delete();
    bus_write(BASE, 32'h55);
    check("t2_tx_before_pop", 32'(tx), 32'h1);
    check("t2_status_queued", rd, 32'h0000_0100);
    b = 8'h55;
    for (int k = 0; k < 40; k++) begin
      logic exp_tx;
      tick();
      if (k < 4)       exp_tx = 1'b0;
      else if (k < 36) exp_tx = b[(k - 4) / 4];
      else             exp_tx = 1'b1;
      check($sformatf("t2_tx_c%0d", k), 32'(tx), 32'(exp_tx));
      check($sformatf("t2_busy_c%0d", k), rd, 32'h0000_0005);
    end
    tick();
    check("t2_status_after", rd, 32'h0000_0001);
    check("t2_tx_after", 32'(tx), 32'h1);
    check("t2_rx_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("t2_rx_byte", 32'(rx_q[0]), 32'h55);

    // 3. Ten writes on consecutive edges into an 8-deep FIFO
    rx_q.delete();
    rx_start.delete();
    for (int i = 1; i <= 10; i++) begin
      we   = 1'b1;
      addr = BASE;
      wd   = 32'(i);
      tick();
    end
    we = 1'b0;
    read_check("t3_status_full", BASE + 32'h4, 32'h0000_080E);

    // 4. Overflow clear while the FIFO stays full
    bus_write(BASE + 32'h4, 32'h8);
    check("t4_ovf_cleared", rd, 32'h0000_0806);
    bus_write(BASE + 32'h4, 32'h0);
    check("t4_ovf_stays_clear", rd, 32'h0000_0806);
    read_check("t4_addr_lsbs_ignored", BASE + 32'h7, 32'h0000_0806);
    addr = BASE + 32'h4;

    waited = 0;
    while (rx_q.size() < 9 && waited < 1000) begin
      tick();
      waited++;
    end
    check("t3_rx_in_time", 32'(waited < 1000), 32'h1);
    repeat (60) tick();
    check("t3_rx_count", rx_q.size(), 32'd9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      check($sformatf("t3_rx_byte%0d", i), 32'(rx_q[i]), 32'(i + 1));
      if (i > 0) check($sformatf("t3_gap%0d", i), rx_start[i] - rx_start[i - 1], GAP);
    end
    read_check("t3_status_done", BASE + 32'h4, 32'h0000_0001);

    // 5. Asynchronous reset in the middle of a frame
    bus_write(BASE, 32'h00);
    bus_write(BASE, 32'h11);
    bus_write(BASE, 32'h22);
    bus_write(BASE, 32'h33);
    repeat (8) tick();
    read_check("t5_status_mid", BASE + 32'h4, 32'h0000_0304);
    check("t5_tx_low_mid", 32'(tx), 32'h0);
    #2;
    rstn = 1'b0;
    #2;
    check("t5_tx_async_high", 32'(tx), 32'h1);
    check("t5_status_in_rst", rd, 32'h0000_0001);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    read_check("t5_status_after", BASE + 32'h4, 32'h0000_0001);
    rx_q.delete();
    rx_start.delete();
    low_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (tx !== 1'b1) low_cnt++;
    end
    check("t5_tx_idle_cycles", low_cnt, 32'd0);
    check("t5_no_frames", rx_start.size(), 32'd0);
    check("t5_status_end", rd, 32'h0000_0001);

    // 6. Writes outside TXDATA/STATUS have no effect
    bus_write(BASE + 32'h100, 32'hAA);
    read_check("t6_outside_read", BASE + 32'h100, 32'h0);
    read_check("t6_outside_status", BASE + 32'h4, 32'h0000_0001);
    bus_write(BASE + 32'h8, 32'hAA);
    read_check("t6_reg8_read", BASE + 32'h8, 32'h0);
    read_check("t6_regc_read", BASE + 32'hC, 32'h0);
    read_check("t6_reg8_status", BASE + 32'h4, 32'h0000_0001);
    low_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1) low_cnt++;
    end
    check("t6_tx_idle_cycles", low_cnt, 32'd0);
    check("t6_no_frames", rx_start.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
